dump_unit: RTL and testbench
============================

DUMP_UNIT -- requirements
Module: dump_unit

Interface
REQ-001 Parameter: CLK_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter: DUMP_BASE, default 32'h0000_0000, byte address of the first word dumped.
REQ-003 Parameter: DUMP_WORDS, default 256, number of 32-bit words dumped.
REQ-004 Port: clk  in  1  system clock; the only clock.
REQ-005 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-006 Port: core_end  in  1  core finished; dump is triggered on its rising edge.
REQ-007 Port: data_ready_io  in  1  data RAM read-data valid for the current memread_io request.
REQ-008 Port: data_from_memory_io  in  32  data RAM read word.
REQ-009 Port: addr_io  out  32  data RAM byte address.
REQ-010 Port: memread_io  out  1  data RAM read request.
REQ-011 Port: txd  out  1  UART serial output, 8N1, idle high.
REQ-012 Port: dump_busy  out  1  dump in progress.
REQ-013 Port: dump_done  out  1  dump complete; sticky until reset.

Function
REQ-014 The block SHALL implement the states IDLE, REQ, WAIT, SEND, NEXT and DONE.
REQ-015 IDLE SHALL move to REQ when core_end is 1 and was 0 in the previous cycle; move to DONE instead when DUMP_WORDS==0.
REQ-016 REQ SHALL drive addr_io = DUMP_BASE + 4*word_idx, assert memread_io, and go to WAIT next cycle.
REQ-017 WAIT SHALL hold memread_io=1 and addr_io stable until data_ready_io is sampled 1, then latch data_from_memory_io, drop memread_io, and go to SEND.
REQ-018 SEND SHALL transmit the latched word as 4 bytes, little-endian (bits 7:0 first), each byte framed as start(0), 8 data bits LSB first, stop(1).
REQ-019 Each bit SHALL last exactly CLK_PER_BIT cycles; the next start bit SHALL begin no more than 2 cycles after the previous stop bit ends.
REQ-020 After byte 3's stop bit, NEXT SHALL increment word_idx (32-bit); go to REQ if word_idx < DUMP_WORDS, else go to DONE.
REQ-021 DONE SHALL hold txd=1, dump_busy=0, dump_done=1, memread_io=0 until reset; further core_end edges are ignored.
REQ-022 dump_busy SHALL be 1 in REQ, WAIT, SEND and NEXT, and 0 in IDLE and DONE.
REQ-023 data_ready_io outside WAIT SHALL be ignored.
REQ-024 core_end edges while busy SHALL be ignored; a core_end already high at reset release SHALL NOT trigger a dump until it falls and rises again.
REQ-025 addr_io SHALL wrap modulo 2^32 without error.
REQ-026 WAIT has no timeout; it waits for data_ready_io indefinitely.

Reset
REQ-027 Asserting rstn=0 SHALL immediately force state IDLE, txd=1, memread_io=0, addr_io=0, dump_busy=0, dump_done=0, word_idx=0, bit and baud counters 0, and the core_end edge register 0.
REQ-028 Reset mid-frame SHALL abort the frame with txd high; no partial byte resumes after reset.

Structure
REQ-029 State encodings, the UART frame constants (start=0, stop=1, 8 data bits) and the default CLK_PER_BIT SHALL live in a shared package used by the existing io receiver.
REQ-030 Byte serialisation SHALL be a sub-module uart_tx with ports clk, rstn, tx_start, tx_data[7:0], tx_ready, txd.
REQ-031 uart_tx SHALL accept a byte only when tx_ready=1 and tx_start=1.

Verification
REQ-032 Scenario: CLK_PER_BIT=4, DUMP_WORDS=1, RAM[0]=32'hA1B2C3D4, pulse core_end -> txd carries bytes D4,C3,B2,A1, each 40 cycles of framing; dump_done rises after the last stop bit.
REQ-033 Scenario: DUMP_WORDS=3, DUMP_BASE=32'h100 -> addr_io sequence 100,104,108; 12 bytes sent; memread_io asserted exactly 3 times.
REQ-034 Scenario: data_ready_io delayed 7 cycles after memread_io -> memread_io and addr_io stay stable 7 cycles; txd stays high until data arrives; data captured correctly.
REQ-035 Scenario: rstn=0 during bit 3 of byte 2 -> txd=1 and dump_busy=0 the same cycle; after release no activity until a new core_end rising edge.
REQ-036 Scenario: DUMP_WORDS=0 with core_end pulse -> dump_done=1 within 2 cycles, no memread_io, txd constantly 1.
REQ-037 Scenario: second core_end pulse during SEND and stray data_ready_io in IDLE -> no extra request, byte stream unchanged.

Source files
------------

// File: rtl/dump_unit_pkg.sv
// Shared definitions for the memory dump unit and the io UART blocks:
// dump FSM encodings, 8N1 frame constants and the default baud divider.
package dump_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } dump_state_e;

    localparam logic UART_START_BIT      = 1'b0;
    localparam logic UART_STOP_BIT       = 1'b1;
    localparam int   UART_DATA_BITS      = 8;
    localparam int   UART_FRAME_BITS     = UART_DATA_BITS + 2;

    // 100 MHz system clock, 115200 baud
    localparam int   DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/dump_unit_uart_tx.sv
// 8N1 UART byte serialiser. A byte is taken when tx_ready and tx_start are
// both high; the whole 10-bit frame is then shifted out LSB first, each bit
// lasting CLK_PER_BIT cycles. tx_ready returns high in the cycle after the
// stop bit ends.
module uart_tx
    import dump_unit_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    logic                       busy_q, busy_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]           baud_cnt_q, baud_cnt_d;

    // Frame/baud state registers; reset drops any frame in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q     <= 1'b0;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

    // Load a frame on accept, otherwise advance one bit per baud period
    always_comb begin
        busy_d     = busy_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        if (!busy_q) begin
            if (tx_start) begin
                busy_d     = 1'b1;
                shift_d    = {UART_STOP_BIT, tx_data, UART_START_BIT};
                bit_cnt_d  = '0;
                baud_cnt_d = '0;
            end
        end else if (baud_cnt_q == CNT_W'(CLK_PER_BIT - 1)) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'(UART_FRAME_BITS - 1)) begin
                busy_d = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {UART_STOP_BIT, shift_q[UART_FRAME_BITS-1:1]};
            end
        end else begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
    end

    assign tx_ready = ~busy_q;
    // Line idles high whenever no frame is active, including during reset
    assign txd      = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/dump_unit.sv
// Dumps DUMP_WORDS 32-bit words of data RAM, starting at DUMP_BASE, over the
// UART once the core signals completion. Each word is read through the
// memread/data_ready handshake and sent as four little-endian 8N1 bytes.
module dump_unit
    import dump_unit_pkg::*;
#(
    parameter int          CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter logic [31:0] DUMP_BASE   = 32'h0000_0000,
    parameter int          DUMP_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        core_end,
    input  logic        data_ready_io,
    input  logic [31:0] data_from_memory_io,
    output logic [31:0] addr_io,
    output logic        memread_io,
    output logic        txd,
    output logic        dump_busy,
    output logic        dump_done
);

    dump_state_e state_q, state_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic        core_end_q, core_end_d;
    logic        armed_q, armed_d;

    logic        core_end_rise;
    logic        tx_start;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [31:0] word_idx_inc;

    // A core_end already high when reset releases must not count as an edge,
    // so edges are only honoured once one cycle of history has been taken
    assign core_end_rise = core_end & ~core_end_q & armed_q;
    assign word_idx_inc  = word_idx_q + 32'd1;
    assign tx_data       = word_q[{byte_cnt_q[1:0], 3'b000} +: 8];

    // Dump FSM and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            core_end_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            core_end_q <= core_end_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state logic and RAM/UART control outputs
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        core_end_d = core_end;
        armed_d    = 1'b1;
        tx_start   = 1'b0;
        memread_io = 1'b0;
        addr_io    = '0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (core_end_rise) begin
                    word_idx_d = '0;
                    state_d    = (DUMP_WORDS == 0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                dump_busy  = 1'b1;
                memread_io = 1'b1;
                addr_io    = DUMP_BASE + (word_idx_q << 2);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                dump_busy  = 1'b1;
                memread_io = 1'b1;
                addr_io    = DUMP_BASE + (word_idx_q << 2);
                if (data_ready_io) begin
                    word_d     = data_from_memory_io;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                dump_busy = 1'b1;
                // byte_cnt counts bytes handed to the UART; the word is done
                // once all four are handed over and the UART is idle again
                if (!byte_cnt_q[2]) begin
                    tx_start = tx_ready;
                    if (tx_ready) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end else if (tx_ready) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                dump_busy  = 1'b1;
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc < 32'(DUMP_WORDS)) ? ST_REQ : ST_DONE;
            end
            ST_DONE: begin
                dump_done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    uart_tx #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rstn    (rstn),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .txd     (txd)
    );

endmodule

// File: tb/tb_dump_unit.sv
// Scoreboard bench for dump_unit with CLK_PER_BIT=4. Expected RAM addresses
// and UART bytes are queued by the stimulus; monitors decode the bus and the
// serial line and pop/compare independently.
module tb_dump_unit;

    localparam int CPB = 4;

    logic        clk;
    logic        rstn;
    logic        core_end;
    logic        ram_ready;
    logic        stray_ready;
    logic        data_ready_io;
    logic [31:0] ram_data;
    logic [31:0] addr_io;
    logic        memread_io;
    logic        txd;
    logic        dump_busy;
    logic        dump_done;

    // second instance with an empty dump range
    logic        zero_ready;
    logic [31:0] zero_data;
    logic [31:0] addr0;
    logic        memread0;
    logic        txd0;
    logic        busy0;
    logic        done0;

    int          checks;
    int          passes;
    int          cyc;
    int          mr_edges;
    int          bytes_seen;
    int          word_pos;
    int          last_start_cyc;
    int          ram_delay;
    bit          dut0_bad;

    logic [31:0] exp_addr[$];
    logic [7:0]  exp_bytes[$];

    assign data_ready_io = ram_ready | stray_ready;
    assign zero_ready    = 1'b0;
    assign zero_data     = 32'h0;

    dump_unit #(
        .CLK_PER_BIT(CPB),
        .DUMP_BASE  (32'h0000_0100),
        .DUMP_WORDS (3)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .core_end           (core_end),
        .data_ready_io      (data_ready_io),
        .data_from_memory_io(ram_data),
        .addr_io            (addr_io),
        .memread_io         (memread_io),
        .txd                (txd),
        .dump_busy          (dump_busy),
        .dump_done          (dump_done)
    );

    dump_unit #(
        .CLK_PER_BIT(CPB),
        .DUMP_BASE  (32'h0000_0000),
        .DUMP_WORDS (0)
    ) dut0 (
        .clk                (clk),
        .rstn               (rstn),
        .core_end           (core_end),
        .data_ready_io      (zero_ready),
        .data_from_memory_io(zero_data),
        .addr_io            (addr0),
        .memread_io         (memread0),
        .txd                (txd0),
        .dump_busy          (busy0),
        .dump_done          (done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: ram_word = 32'hA1B2_C3D4;
            32'h0000_0104: ram_word = 32'h1122_3344;
            32'h0000_0108: ram_word = 32'hDEAD_BEEF;
            default:       ram_word = 32'hBAD0_BAD0;
        endcase
    endfunction

    // Hand-computed little-endian byte stream for the three words above
    task automatic push_full_dump();
        logic [7:0] stream [12];
        stream = '{8'hD4, 8'hC3, 8'hB2, 8'hA1,
                   8'h44, 8'h33, 8'h22, 8'h11,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_addr.push_back(32'h0000_0100);
        exp_addr.push_back(32'h0000_0104);
        exp_addr.push_back(32'h0000_0108);
        for (int i = 0; i < 12; i++) exp_bytes.push_back(stream[i]);
    endtask

    task automatic pulse_core_end();
        @(negedge clk) core_end = 1'b1;
        @(negedge clk) core_end = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !dump_done; i++) @(negedge clk);
        check("dump_done_reached", dump_done, 1);
        check("done_after_last_stop",
              ((cyc - last_start_cyc) >= 40) && ((cyc - last_start_cyc) <= 44), 1);
    endtask

    // RAM model: answers a request after ram_delay cycles
    initial begin
        ram_ready = 1'b0;
        ram_data  = '0;
        forever begin
            @(negedge clk);
            if (memread_io && !ram_ready) begin
                for (int i = 0; i < ram_delay; i++) begin
                    @(negedge clk);
                    check("txd_high_while_waiting", txd, 1);
                    check("memread_held", memread_io, 1);
                end
                ram_data  = ram_word(addr_io);
                ram_ready = 1'b1;
                @(negedge clk);
                ram_ready = 1'b0;
                ram_data  = '0;
            end
        end
    end

    // Request monitor: one expected address per memread rising edge
    initial begin
        logic        mr_prev;
        logic [31:0] held;
        mr_prev = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (memread_io && !mr_prev) begin
                mr_edges++;
                check("request_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("req_addr", addr_io, exp_addr.pop_front());
                held = addr_io;
            end else if (memread_io) begin
                check("addr_stable", addr_io, held);
            end
            mr_prev = memread_io;
            if (rstn && (memread0 || !txd0 || addr0 != 0)) dut0_bad = 1'b1;
        end
    end

    // UART monitor: decode 8N1 frames at bit centres
    initial begin
        logic [7:0] data;
        logic       start_b;
        logic       stop_b;
        bit         abort;
        int         interval;
        forever begin
            @(negedge clk);
            if (rstn && txd == 1'b0) begin
                interval = cyc - last_start_cyc;
                last_start_cyc = cyc;
                abort = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                start_b = txd;
                if (!rstn) abort = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    data[b] = txd;
                    if (!rstn) abort = 1'b1;
                end
                repeat (CPB) @(negedge clk);
                stop_b = txd;
                if (!rstn) abort = 1'b1;
                if (abort) begin
                    word_pos = 0;
                end else begin
                    check("start_bit", start_b, 0);
                    check("stop_bit", stop_b, 1);
                    if (word_pos != 0) check("byte_spacing", (interval >= 40) && (interval <= 42), 1);
                    check("byte_expected", exp_bytes.size() != 0, 1);
                    if (exp_bytes.size() != 0) check("byte_value", data, exp_bytes.pop_front());
                    $display("byte %0d: %h", bytes_seen, data);
                    bytes_seen++;
                    word_pos = (word_pos + 1) % 4;
                end
            end
        end
    end

    initial begin
        int  base;
        bit  activity;
        checks = 0; passes = 0; cyc = 0; mr_edges = 0; bytes_seen = 0;
        word_pos = 0; last_start_cyc = 0; dut0_bad = 1'b0;
        rstn = 1'b0; core_end = 1'b1; stray_ready = 1'b0; ram_delay = 1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_memread", memread_io, 0);
        check("rst_addr", addr_io, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_done", dump_done, 0);

        // core_end high at release must not trigger
        @(negedge clk) rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("no_trigger_busy", dump_busy, 0);
        check("no_trigger_req", mr_edges, 0);
        check("no_trigger_done0", done0, 0);
        core_end = 1'b0;
        repeat (5) @(negedge clk);

        // Stray data_ready while idle
        stray_ready = 1'b1;
        repeat (3) @(negedge clk);
        stray_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ready_busy", dump_busy, 0);
        check("stray_ready_req", mr_edges, 0);

        // Full dump, 7-cycle RAM latency, extra core_end during SEND
        ram_delay = 7;
        push_full_dump();
        pulse_core_end();
        @(negedge clk);
        check("zero_words_done", done0, 1);
        check("zero_words_busy", busy0, 0);
        repeat (60) @(negedge clk);
        check("busy_in_send", dump_busy, 1);
        pulse_core_end();
        wait_done(3000);
        check("run1_requests", mr_edges, 3);
        check("run1_bytes_left", exp_bytes.size(), 0);
        check("run1_addr_left", exp_addr.size(), 0);
        check("run1_busy", dump_busy, 0);
        check("run1_txd", txd, 1);
        check("run1_memread", memread_io, 0);

        // Edge after DONE is ignored
        pulse_core_end();
        repeat (30) @(negedge clk);
        check("post_done_requests", mr_edges, 3);
        check("post_done_sticky", dump_done, 1);

        // Reset clears done, then abort mid-frame (bit 3 of byte 2)
        @(negedge clk) rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("done_cleared", dump_done, 0);
        check("done0_cleared", done0, 0);
        ram_delay = 2;
        exp_addr.push_back(32'h0000_0100);
        exp_bytes.push_back(8'hD4);
        exp_bytes.push_back(8'hC3);
        base = bytes_seen;
        pulse_core_end();
        for (int i = 0; i < 400 && bytes_seen != base + 2; i++) @(negedge clk);
        check("bytes_before_reset", bytes_seen, base + 2);
        for (int i = 0; i < 20 && txd != 1'b0; i++) @(negedge clk);
        check("byte2_start_seen", txd, 0);
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_txd", txd, 1);
        check("abort_busy", dump_busy, 0);
        check("abort_memread", memread_io, 0);
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!txd || memread_io || dump_busy) activity = 1'b1;
        end
        check("quiet_after_reset", activity, 0);
        check("abort_requests", mr_edges, 4);
        check("abort_bytes_left", exp_bytes.size(), 0);

        // Fresh dump restarts from word 0
        ram_delay = 1;
        push_full_dump();
        pulse_core_end();
        wait_done(3000);
        check("run3_requests", mr_edges, 7);
        check("run3_bytes_left", exp_bytes.size(), 0);
        check("run3_addr_left", exp_addr.size(), 0);
        check("zero_words_quiet", dut0_bad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
